wbm_split_master: RTL and testbench
===================================

# wbm_split_master

Wishbone classic single-transfer master that converts 64-bit accelerator-side requests into one or two 32-bit bus beats, using the lower/upper word convention of the accelerator's Wishbone slave: word address = region base + (index<<1) + 0 for the lower word and + 1 for the upper word. It sits between the on-chip debug/loader sequencer and the Wishbone slave controller. It preloads and reads back query-patch, leaf and node memories and programs the mode/debug registers without a host CPU.

## Interface
Parameters:
- IDX_W, 16: width of req_index (memory entry index).
- TIMEOUT, 255: max cycles a beat may wait for ack before abort; must be ≥ 1.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_wide  in  1  1 = two beats (lower then upper), 0 = lower beat only.
- req_base  in  32  region base (e.g. 32'h3100_0000 query, 32'h3200_0000 leaf, 32'h3400_0000 node, 32'h3000_0000 regs).
- req_index  in  IDX_W  entry index.
- req_wdata  in  64  write data; [31:0] lower beat, [63:32] upper beat.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  64  read data; [31:0] lower, [63:32] upper (0 for unused half).
- rsp_err  out  1  valid with rsp_valid; 1 = ack timeout.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select; always 4'hF during a beat, 0 otherwise.
- wbm_adr_o  out  32  word address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

## Operation
- States: IDLE, LO, GAP, HI, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields, clear rsp_rdata, go to LO. req_ready=0 in every other state.
- LO: cyc=stb=1, we=latched we, adr=base+(index<<1), dat_o=wdata[31:0]. On ack: if read, capture wbm_dat_i into rdata[31:0]. Then go to GAP if wide, else to RESP.
- GAP: stb=0, cyc=1 (cycle held between beats), sel=0. Unconditionally go to HI next cycle.
- HI: cyc=stb=1, adr=base+(index<<1)+1, dat_o=wdata[63:32]. On ack: if read, capture wbm_dat_i into rdata[63:32]. Then go to RESP.
- RESP: cyc=stb=0, rsp_valid=1 for exactly one cycle, then go to IDLE. No backpressure on the response.
- Address arithmetic: 32-bit modular; index is zero-extended before the shift; carries past bit 31 are discarded.
- Timeout: a counter clears on entry to LO/HI and increments each cycle stb=1 without ack. When it reaches TIMEOUT with no ack: drop cyc/stb, go to RESP with rsp_err=1. rsp_rdata keeps any half already captured; the missing half is 0. The HI beat is not issued after a LO timeout.
- wbm_ack_i is ignored in IDLE, GAP and RESP.
- wbm_dat_o and wbm_adr_o are 0 whenever stb=0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, cyc=stb=we=0, sel=0, adr=0, dat_o=0; state IDLE.
- Reset mid-transfer: on the next edge all bus outputs are 0 and state is IDLE. The interrupted request produces no response.
- Request accepted at edge T (valid&ready high). cyc/stb are asserted from T+1.
- Ack sampled high at an edge ends the beat. stb is low in the following cycle.
- Zero-wait slave, narrow request: accept at T, LO T+1, RESP T+2. rsp_valid is high in cycle T+2 and req_ready is high at T+3.
- Zero-wait slave, wide request: LO T+1, GAP T+2, HI T+3, RESP T+4, ready at T+5.
- Each slave wait cycle adds exactly one cycle of latency.
- Timeout: with no ack, stb stays high for exactly TIMEOUT cycles, then RESP.

## Test plan
- Narrow write: base 32'h3000_0001, index 0, wdata 1, zero-wait ack -> one beat at adr 32'h3000_0001 with dat 1 and we=1; rsp_valid at T+2 with err=0.
- Wide read: base 32'h3100_0000, index 1; slave returns 32'hDEAD_BEEF then 32'h0000_1010 with 2 wait cycles each -> beats at 32'h3100_0002 then 32'h3100_0003; cyc held through GAP; rsp_rdata=64'h0000_1010_DEAD_BEEF.
- Wide write: base 32'h3200_0000, index 3, wdata 64'hFEDC_BA98_7654_3210 -> lower beat 32'h7654_3210 at 32'h3200_0006, upper beat 32'hFEDC_BA98 at 32'h3200_0007.
- Timeout: TIMEOUT=8, wide read, slave never acks -> stb high for 8 cycles, no HI beat, rsp_err=1, rsp_rdata=0.
- Reset mid-transfer: assert wb_rst_i during the HI wait -> next cycle cyc=stb=0, req_ready=1, no rsp_valid pulse.
- Stray ack in IDLE, and a new req_valid held during RESP -> no state change from the ack; the new request is accepted only when req_ready is high again.

Source files
------------

// File: rtl/wbm_split_master.sv
// wbm_split_master
// Wishbone classic single-transfer master. A 64-bit accelerator request
// becomes one (narrow) or two (wide) 32-bit beats. The lower word is at
// base + (index << 1) and the upper word at base + (index << 1) + 1.
// Between the two beats there is a one-cycle gap with CYC held and STB low.
// Each beat is aborted after TIMEOUT strobe cycles without an ack. An abort
// ends the request with rsp_err set.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   req_valid / req_ready     request handshake (ready only while idle)
//   req_we, req_wide          write flag, two-beat flag
//   req_base, req_index       region base, entry index
//   req_wdata                 write data, [31:0] lower / [63:32] upper
//   rsp_valid                 one-cycle response pulse
//   rsp_rdata, rsp_err        read data and ack-timeout flag
//   wbm_*                     Wishbone classic master signals

module wbm_split_master #(
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_wide,
    input  logic [31:0]      req_base,
    input  logic [IDX_W-1:0] req_index,
    input  logic [63:0]      req_wdata,
    output logic             rsp_valid,
    output logic [63:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        GAP,
        HI,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic               wide_q, wide_d;
    logic [31:0]        base_q, base_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [TW-1:0]      tmo_q, tmo_d;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            wide_q  <= 1'b0;
            base_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wide_q  <= wide_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        wide_d  = wide_q;
        base_d  = base_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    wide_d  = req_wide;
                    base_d  = req_base;
                    idx_d   = req_index;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = LO;
                end
            end
            LO: begin
                if (wbm_ack_i) begin
                    if (!we_q) rdata_d[31:0] = wbm_dat_i;
                    state_d = wide_q ? GAP : RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Last permitted strobe cycle without ack: abort, skip HI.
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GAP: begin
                tmo_d   = '0;
                state_d = HI;
            end
            HI: begin
                if (wbm_ack_i) begin
                    if (!we_q) rdata_d[63:32] = wbm_dat_i;
                    state_d = RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs (Moore: decoded from the registered state)
    logic        beat;
    logic [31:0] lo_adr;

    always_comb begin
        beat       = (state_q == LO) || (state_q == HI);
        lo_adr     = base_q + (32'(idx_q) << 1);

        req_ready  = (state_q == IDLE);
        rsp_valid  = (state_q == RESP);
        rsp_err    = (state_q == RESP) && err_q;
        rsp_rdata  = rdata_q;

        wbm_cyc_o  = beat || (state_q == GAP);
        wbm_stb_o  = beat;
        wbm_we_o   = beat && we_q;
        wbm_sel_o  = beat ? 4'hF : 4'h0;
        wbm_adr_o  = '0;
        wbm_dat_o  = '0;
        if (state_q == LO) begin
            wbm_adr_o = lo_adr;
            wbm_dat_o = wdata_q[31:0];
        end else if (state_q == HI) begin
            wbm_adr_o = lo_adr + 32'd1;
            wbm_dat_o = wdata_q[63:32];
        end
    end

endmodule

// File: tb/tb_wbm_split_master.sv
// Testbench for wbm_split_master: a directed-transaction timeline model with a
// per-cycle compare process, plus literal checks on recorded bus activity.

module tb_wbm_split_master;

    localparam int IDX_W = 16;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic             req_wide;
    logic [31:0]      req_base;
    logic [IDX_W-1:0] req_index;
    logic [63:0]      req_wdata;
    logic             rsp_valid;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic             wbm_ack_i;
    logic [31:0]      wbm_dat_i;

    always #5 clk = ~clk;

    wbm_split_master #(
        .IDX_W   (IDX_W),
        .TIMEOUT (TMO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wide  (req_wide),
        .req_base  (req_base),
        .req_index (req_index),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    typedef struct {
        logic        rdy, cyc, stb, we;
        logic [3:0]  sel;
        logic [31:0] adr, dat;
        logic        rv, err;
        logic [63:0] rdata;
        bit          chk_we, chk_rsp;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_n = 0;
    int          acc_cyc = 0, rsp_cyc = 0, stb_cnt = 0, rsp_cnt = 0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] badr[$];
    logic [31:0] bdat[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h want %h", name, cyc_n, got, want);
        end
    endtask

    // Monitor + compare, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        if (wbm_stb_o === 1'b1) stb_cnt++;
        if (wbm_stb_o === 1'b1 && wbm_ack_i) begin
            badr.push_back(wbm_adr_o);
            bdat.push_back(wbm_dat_o);
        end
        if (req_valid && req_ready === 1'b1) acc_cyc = cyc_n;
        if (rsp_valid === 1'b1) begin
            rsp_cyc    = cyc_n;
            rsp_cnt++;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_ready", 64'(req_ready), 64'(e.rdy));
            chk("cyc",       64'(wbm_cyc_o), 64'(e.cyc));
            chk("stb",       64'(wbm_stb_o), 64'(e.stb));
            chk("sel",       64'(wbm_sel_o), 64'(e.sel));
            chk("adr",       64'(wbm_adr_o), 64'(e.adr));
            chk("dat_o",     64'(wbm_dat_o), 64'(e.dat));
            chk("rsp_valid", 64'(rsp_valid), 64'(e.rv));
            if (e.chk_we) chk("we", 64'(wbm_we_o), 64'(e.we));
            if (e.chk_rsp) begin
                chk("rsp_err",   64'(rsp_err), 64'(e.err));
                chk("rsp_rdata", rsp_rdata,    e.rdata);
            end
        end
    end

    function automatic exp_t idle_e();
        exp_t e;
        e.rdy = 1'b1; e.cyc = 1'b0; e.stb = 1'b0; e.we = 1'b0; e.sel = 4'h0;
        e.adr = '0; e.dat = '0; e.rv = 1'b0; e.err = 1'b0; e.rdata = '0;
        e.chk_we = 1'b0; e.chk_rsp = 1'b0;
        return e;
    endfunction

    function automatic exp_t reset_e();
        exp_t e = idle_e();
        e.chk_we = 1'b1; e.chk_rsp = 1'b1;
        return e;
    endfunction

    function automatic exp_t beat_e(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        exp_t e = idle_e();
        e.rdy = 1'b0; e.cyc = 1'b1; e.stb = 1'b1; e.we = we; e.sel = 4'hF;
        e.adr = adr; e.dat = dat; e.chk_we = 1'b1;
        return e;
    endfunction

    function automatic exp_t gap_e();
        exp_t e = idle_e();
        e.rdy = 1'b0; e.cyc = 1'b1;
        return e;
    endfunction

    function automatic exp_t resp_e(input logic err, input logic [63:0] rd);
        exp_t e = idle_e();
        e.rdy = 1'b0; e.rv = 1'b1; e.err = err; e.rdata = rd; e.chk_rsp = 1'b1;
        return e;
    endfunction

    // Push expectation for the current cycle; inputs already set are sampled at the next edge.
    task automatic cycle(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic scramble_req();
        req_we    = 1'($urandom);
        req_wide  = 1'($urandom);
        req_base  = $urandom;
        req_index = IDX_W'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            wbm_ack_i = ack;
            wbm_dat_i = $urandom;
            cycle(idle_e());
        end
        wbm_ack_i = 1'b0;
    endtask

    task automatic clear_mon();
        badr.delete();
        bdat.delete();
        stb_cnt = 0;
        rsp_cnt = 0;
    endtask

    // One beat: w = ack after w wait cycles, or -1 for no ack (timeout).
    task automatic beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input int w, input logic [31:0] rd);
        int n = (w < 0) ? TMO : w + 1;
        for (int i = 0; i < n; i++) begin
            wbm_ack_i = (i == w);
            wbm_dat_i = (i == w) ? rd : $urandom;
            cycle(beat_e(we, adr, dat));
        end
    endtask

    // Whole transaction timeline from the request fields and slave behaviour.
    task automatic txn(input logic we, input logic wide, input logic [31:0] base,
                       input logic [IDX_W-1:0] idx, input logic [63:0] wd,
                       input int w_lo, input int w_hi,
                       input logic [31:0] rd_lo, input logic [31:0] rd_hi,
                       input bit junk_in_resp);
        logic [31:0] a0 = base + 32'(idx) * 32'd2;
        logic [63:0] rd = '0;
        logic        err = 1'b0;

        req_valid = 1'b1; req_we = we; req_wide = wide; req_base = base;
        req_index = idx; req_wdata = wd; wbm_ack_i = 1'b0; wbm_dat_i = $urandom;
        cycle(idle_e());
        req_valid = 1'b0;
        scramble_req();

        beat(we, a0, wd[31:0], w_lo, rd_lo);
        if (w_lo < 0) err = 1'b1;
        else if (!we) rd[31:0] = rd_lo;

        if (!err && wide) begin
            wbm_ack_i = 1'b1;           // stray ack in GAP
            wbm_dat_i = $urandom;
            cycle(gap_e());
            beat(we, a0 + 32'd1, wd[63:32], w_hi, rd_hi);
            if (w_hi < 0) err = 1'b1;
            else if (!we) rd[63:32] = rd_hi;
        end

        wbm_ack_i = 1'b1;               // stray ack in RESP
        wbm_dat_i = $urandom;
        req_valid = junk_in_resp;
        cycle(resp_e(err, rd));
        req_valid = 1'b0;
        wbm_ack_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0;
        req_base = '0; req_index = '0; req_wdata = '0;
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        @(posedge clk);
        #2;
        cycle(reset_e());
        rst = 1'b0;
        cycle(reset_e());

        // Narrow write, zero wait
        clear_mon();
        txn(1'b1, 1'b0, 32'h3000_0001, 16'd0, 64'h1, 0, 0, 32'h0, 32'h0, 1'b0);
        chk("nw_beats", 64'(badr.size()), 64'd1);
        chk("nw_adr", 64'(badr[0]), 64'h3000_0001);
        chk("nw_dat", 64'(bdat[0]), 64'h1);
        chk("nw_latency", 64'(rsp_cyc - acc_cyc), 64'd2);
        chk("nw_err", 64'(last_err), 64'd0);
        idle(1, 1'b0);

        // Wide read, two wait cycles per beat
        clear_mon();
        txn(1'b0, 1'b1, 32'h3100_0000, 16'd1, 64'h0, 2, 2, 32'hDEAD_BEEF, 32'h0000_1010, 1'b0);
        chk("wr_rdata", last_rdata, 64'h0000_1010_DEAD_BEEF);
        chk("wr_adr0", 64'(badr[0]), 64'h3100_0002);
        chk("wr_adr1", 64'(badr[1]), 64'h3100_0003);
        chk("wr_latency", 64'(rsp_cyc - acc_cyc), 64'd8);
        idle(1, 1'b0);

        // Wide write, zero wait
        clear_mon();
        txn(1'b1, 1'b1, 32'h3200_0000, 16'd3, 64'hFEDC_BA98_7654_3210, 0, 0, 32'h0, 32'h0, 1'b0);
        chk("ww_adr0", 64'(badr[0]), 64'h3200_0006);
        chk("ww_dat0", 64'(bdat[0]), 64'h7654_3210);
        chk("ww_adr1", 64'(badr[1]), 64'h3200_0007);
        chk("ww_dat1", 64'(bdat[1]), 64'hFEDC_BA98);
        chk("ww_latency", 64'(rsp_cyc - acc_cyc), 64'd4);
        chk("ww_rdata", last_rdata, 64'h0);
        idle(1, 1'b0);

        // Timeout on the lower beat of a wide read
        clear_mon();
        txn(1'b0, 1'b1, 32'h3100_0000, 16'h0010, 64'h0, -1, 0, 32'h0, 32'h0, 1'b0);
        chk("to_stb_cycles", 64'(stb_cnt), 64'd8);
        chk("to_beats", 64'(badr.size()), 64'd0);
        chk("to_err", 64'(last_err), 64'd1);
        chk("to_rdata", last_rdata, 64'h0);
        chk("to_latency", 64'(rsp_cyc - acc_cyc), 64'd9);
        idle(1, 1'b0);

        // Timeout on the upper beat keeps the lower half
        clear_mon();
        txn(1'b0, 1'b1, 32'h3400_0000, 16'd2, 64'h0, 0, -1, 32'hCAFE_F00D, 32'h0, 1'b0);
        chk("toh_rdata", last_rdata, 64'h0000_0000_CAFE_F00D);
        chk("toh_err", 64'(last_err), 64'd1);
        idle(1, 1'b0);

        // Address wraps modulo 2^32
        clear_mon();
        txn(1'b1, 1'b1, 32'hFFFF_FFF0, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 1, 0, 32'h0, 32'h0, 1'b0);
        chk("wrap_adr0", 64'(badr[0]), 64'h0001_FFEE);
        chk("wrap_adr1", 64'(badr[1]), 64'h0001_FFEF);
        idle(1, 1'b0);

        // Reset during the upper-beat wait
        clear_mon();
        req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b1; req_base = 32'h3400_0000;
        req_index = 16'd5; req_wdata = '0; wbm_ack_i = 1'b0;
        cycle(idle_e());
        req_valid = 1'b0;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1111_2222;
        cycle(beat_e(1'b0, 32'h3400_000A, 32'h0));
        wbm_dat_i = $urandom;
        cycle(gap_e());
        wbm_ack_i = 1'b0;
        cycle(beat_e(1'b0, 32'h3400_000B, 32'h0));
        rst = 1'b1;
        cycle(beat_e(1'b0, 32'h3400_000B, 32'h0));
        rst = 1'b0;
        cycle(reset_e());
        idle(3, 1'b0);
        chk("rst_no_rsp", 64'(rsp_cnt), 64'd0);

        // Stray acks while idle, then a request held through RESP
        idle(3, 1'b1);
        clear_mon();
        txn(1'b0, 1'b0, 32'h3200_0000, 16'd2, 64'h0, 0, 0, 32'hA5A5_5A5A, 32'h0, 1'b1);
        txn(1'b0, 1'b0, 32'h3000_0000, 16'd7, 64'h0, 1, 0, 32'h1234_5678, 32'h0, 1'b0);
        chk("b2b_rdata", last_rdata, 64'h0000_0000_1234_5678);
        chk("b2b_adr", 64'(badr[1]), 64'h3000_000E);
        chk("b2b_beats", 64'(badr.size()), 64'd2);
        idle(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
